// File: rtl/pcs_pkg.sv
// Shared PCS constants for the scrambler, gearbox and descrambler.
package pcs_pkg;
   localparam int         DATA_WIDTH = 32;
   localparam int         HDR_WIDTH  = 2;
   localparam int         GB_PERIOD  = 33;
   localparam logic [1:0] SYNC_DATA  = 2'b01;
   localparam logic [1:0] SYNC_CTRL  = 2'b10;
endpackage

// File: rtl/tx_gearbox.sv
// 66b -> 32b transmit gearbox: packs header+payload half-blocks into SerDes words,
// pausing upstream once every GB_PERIOD cycles to drain the surplus header bits.
module tx_gearbox #(
   parameter int DATA_WIDTH = pcs_pkg::DATA_WIDTH,
   parameter int HDR_WIDTH  = pcs_pkg::HDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_data_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_hdr_valid,
   input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_data_valid,
   output logic                  o_align_err
);
   import pcs_pkg::*;

   localparam int CW = 2*DATA_WIDTH + HDR_WIDTH;

   logic [2*DATA_WIDTH-1:0] resid;
   logic [6:0]              fill;
   logic [5:0]              seq;
   logic                    phase;

   logic          pause, accept, hdr_bad;
   logic [CW-1:0] beat, comb;
   logic [6:0]    nbits, total;

   assign pause   = (seq == 6'(GB_PERIOD-1));
   assign o_ready = i_reset | ~pause;
   assign accept  = i_data_valid & o_ready;
   // phase 0 must carry a header, phase 1 must not
   assign hdr_bad = accept & (i_hdr_valid == phase);

   always_comb begin
      beat  = '0;
      nbits = '0;
      if (accept && !hdr_bad) begin
         if (!phase) begin
            beat  = CW'({i_data, i_sync_hdr});
            nbits = 7'(DATA_WIDTH + HDR_WIDTH);
         end else begin
            beat  = CW'(i_data);
            nbits = 7'(DATA_WIDTH);
         end
      end
      comb  = CW'(resid) | (beat << fill);
      total = fill + nbits;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_align_err  <= 1'b0;
         resid        <= '0;
         fill         <= '0;
         seq          <= '0;
         phase        <= 1'b0;
      end else begin
         o_align_err <= hdr_bad;
         if (hdr_bad) begin
            o_data_valid <= 1'b0;
            resid        <= '0;
            fill         <= '0;
            seq          <= '0;
            phase        <= 1'b0;
         end else begin
            if (accept) phase <= ~phase;
            if (accept || pause) seq <= pause ? 6'd0 : seq + 6'd1;
            if (total >= 7'(DATA_WIDTH)) begin
               o_data       <= comb[DATA_WIDTH-1:0];
               o_data_valid <= 1'b1;
               resid        <= (2*DATA_WIDTH)'(comb >> DATA_WIDTH);
               fill         <= total - 7'(DATA_WIDTH);
            end else begin
               o_data_valid <= 1'b0;
               resid        <= comb[2*DATA_WIDTH-1:0];
               fill         <= total;
            end
         end
      end
   end
endmodule

// File: tb/tb_tx_gearbox.sv
// Directed + random bench for tx_gearbox against a bit-queue model of the wire order.
module tb_tx_gearbox;
   import pcs_pkg::*;

   logic        i_clk = 1'b0, i_reset = 1'b1, i_data_valid = 1'b0, i_hdr_valid = 1'b0;
   logic [1:0]  i_sync_hdr = '0;
   logic [31:0] i_data = '0;
   logic        o_ready, o_data_valid, o_align_err;
   logic [31:0] o_data;

   always #5 i_clk = ~i_clk;

   tx_gearbox dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_data_valid(i_data_valid), .i_data(i_data),
      .i_hdr_valid(i_hdr_valid), .i_sync_hdr(i_sync_hdr), .o_ready(o_ready),
      .o_data(o_data), .o_data_valid(o_data_valid), .o_align_err(o_align_err)
   );

   int n_assert = 0, n_fail = 0;
   bit mq[$];
   int mseq = 0;
   bit mphase = 1'b0, last_acc = 1'b0;
   int cyc_n = 0, obs_words = 0, obs_acc = 0;
   int pause_log[$];
   logic [31:0] hd;
   logic [1:0]  hh;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive, check o_ready, advance the model, check registered outputs.
   task automatic cyc(input bit v, input bit hv, input logic [1:0] h, input logic [31:0] d,
                      input bit rst);
      bit exp_err, exp_vld, acc;
      logic [31:0] w;
      i_reset = rst; i_data_valid = v; i_hdr_valid = hv; i_sync_hdr = h; i_data = d;
      #1;
      chk("o_ready", 64'(o_ready), 64'(rst || mseq != GB_PERIOD-1));
      exp_err = 0; exp_vld = 0; acc = 0; w = '0;
      if (rst) begin
         mq.delete(); mseq = 0; mphase = 0;
         cyc_n = 0; obs_words = 0; obs_acc = 0; pause_log.delete();
      end else begin
         cyc_n++;
         if (o_ready === 1'b0) pause_log.push_back(cyc_n);
         if (v && o_ready === 1'b1) obs_acc++;
         acc = v && (mseq != GB_PERIOD-1);
         if (acc && (hv != !mphase)) begin
            exp_err = 1; mq.delete(); mseq = 0; mphase = 0;
         end else begin
            if (acc) begin
               if (!mphase) begin mq.push_back(h[0]); mq.push_back(h[1]); end
               for (int i = 0; i < 32; i++) mq.push_back(d[i]);
               mphase = !mphase;
            end
            if (acc || mseq == GB_PERIOD-1) mseq = (mseq == GB_PERIOD-1) ? 0 : mseq + 1;
            if (mq.size() >= 32) begin
               for (int i = 0; i < 32; i++) w[i] = mq.pop_front();
               exp_vld = 1;
            end
         end
      end
      last_acc = acc;
      @(posedge i_clk); #1;
      if (o_data_valid === 1'b1) obs_words++;
      chk("o_align_err", 64'(o_align_err), 64'(exp_err));
      chk("o_data_valid", 64'(o_data_valid), 64'(exp_vld));
      if (rst || exp_vld) chk(rst ? "o_data_rst" : "o_data", 64'(o_data), rst ? 64'h0 : 64'(w));
   endtask

   task automatic new_beat();
      hd = $urandom;
      hh = ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
   endtask

   // Upstream holds its beat until accepted; bad=1 flips the header flag.
   task automatic beat_cycle(input bit v, input bit bad);
      bit hv;
      hv = (mphase == 1'b0) ^ bad;
      cyc(v, hv, hh, hd, 1'b0);
      if (last_acc) new_beat();
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
      new_beat();
   endtask

   initial begin
      new_beat();
      @(posedge i_clk); #1;
      do_reset();
      do_reset();
      chk("rst_fill", 64'(dut.fill), 64'd0);
      chk("rst_seq", 64'(dut.seq), 64'd0);

      cyc(1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, 1'b0);
      chk("first_word", 64'(o_data), 64'hFFFFFFFD);
      cyc(1'b1, 1'b0, 2'b00, 32'h00000000, 1'b0);
      chk("second_word", 64'(o_data), 64'h3);
      chk("residual_fill", 64'(dut.fill), 64'd2);

      // continuous stream
      do_reset();
      repeat (99) beat_cycle(1'b1, 1'b0);
      chk("stream_pauses", 64'(pause_log.size()), 64'd3);
      chk("stream_pause0", 64'(pause_log[0]), 64'd33);
      chk("stream_pause1", 64'(pause_log[1]), 64'd66);
      chk("stream_pause2", 64'(pause_log[2]), 64'd99);
      chk("stream_accepts", 64'(obs_acc), 64'd96);
      chk("stream_words", 64'(obs_words), 64'd99);

      // valid gap at seq=10
      do_reset();
      repeat (10) beat_cycle(1'b1, 1'b0);
      chk("gap_seq_before", 64'(dut.seq), 64'd10);
      repeat (3) beat_cycle(1'b0, 1'b0);
      chk("gap_seq_hold", 64'(dut.seq), 64'd10);
      repeat (27) beat_cycle(1'b1, 1'b0);
      chk("gap_pauses", 64'(pause_log.size()), 64'd1);
      chk("gap_pause_cycle", 64'(pause_log[0]), 64'd36);

      // header misalignment, both polarities
      do_reset();
      repeat (3) beat_cycle(1'b1, 1'b0);
      beat_cycle(1'b1, 1'b1);
      chk("align_fill", 64'(dut.fill), 64'd0);
      chk("align_seq", 64'(dut.seq), 64'd0);
      beat_cycle(1'b1, 1'b1);
      repeat (6) beat_cycle(1'b1, 1'b0);

      // mid-stream reset at seq=20
      do_reset();
      repeat (20) beat_cycle(1'b1, 1'b0);
      chk("midrst_seq_before", 64'(dut.seq), 64'd20);
      cyc(1'b1, 1'b1, hh, hd, 1'b1);
      new_beat();
      chk("midrst_ready", 64'(o_ready), 64'd1);
      chk("midrst_seq", 64'(dut.seq), 64'd0);
      chk("midrst_fill", 64'(dut.fill), 64'd0);
      repeat (35) beat_cycle(1'b1, 1'b0);
      chk("midrst_pause", 64'(pause_log[0]), 64'd33);

      // random soak with gaps and occasional misalignment
      do_reset();
      repeat (700) beat_cycle(($urandom % 8) != 0, ($urandom % 64) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/tx_gearbox.md
TX_GEARBOX -- requirements
Module: tx_gearbox

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, scrambled payload and output word width; only 32 is supported.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, 64b/66b sync header width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port i_data_valid, input, 1, the scrambler output beat is valid.
REQ-006 SHALL have port i_data, input, 32, the scrambled payload half-block; bit 0 goes first on the wire.
REQ-007 SHALL have port i_hdr_valid, input, 1, marks the first half of a 66-bit block.
REQ-008 SHALL have port i_sync_hdr, input, 2, the sync header; it is sampled only when i_hdr_valid=1, and bit 0 goes first.
REQ-009 SHALL have port o_ready, output, 1, low on pause cycles; upstream holds its beat while it is low.
REQ-010 SHALL have port o_data, output, 32, the SerDes word; bit 0 goes first on the wire.
REQ-011 SHALL have port o_data_valid, output, 1, o_data holds 32 valid bits.
REQ-012 SHALL have port o_align_err, output, 1, a one-cycle pulse on a header/phase mismatch.

Function
REQ-013 SHALL accept a beat only when i_data_valid=1 and o_ready=1.
REQ-014 SHALL keep a block phase bit: 0 expects a header beat, 1 expects a payload-only beat; the bit toggles on every accepted beat.
REQ-015 SHALL, on a phase-0 accept, append {i_data, i_sync_hdr} (34 bits, header at the LSBs) to the residual buffer.
REQ-016 SHALL, on a phase-1 accept, append i_data (32 bits) to the residual buffer.
REQ-017 SHALL keep a fill count of 0..64; new bits go directly above the existing residual bits.
REQ-018 SHALL register o_data on the cycle after fill reaches 32 or more, taking the lowest 32 buffered bits, and then reduce fill by 32 and shift the residual down.
REQ-019 SHALL give a latency of exactly 1 cycle from an accepted beat to the output word containing its first bit.
REQ-020 SHALL keep a sequence counter seq of 0..32 that advances on each accepted beat and on each pause cycle, wrapping from 32 to 0.
REQ-021 SHALL drive o_ready=0 combinationally exactly when seq=32, and SHALL emit the buffered 32 bits on that pause cycle.
REQ-022 SHALL, in steady state, give 32 accepts and 1 pause per 33 cycles, with no drop or duplicate of any bit.
REQ-023 SHALL NOT advance seq on a cycle with i_data_valid=0 and seq!=32.
REQ-024 SHALL drive o_data_valid=0 on the cycle following an idle cycle when fill is below 32.
REQ-025 SHALL, if i_hdr_valid=1 at phase 1, or i_hdr_valid=0 at phase 0, pulse o_align_err, clear fill and seq, discard the beat, and force phase to 0.
REQ-026 SHALL, when a pause cycle coincides with i_data_valid=1, hold off the beat; it is not lost.

Reset
REQ-027 SHALL, on i_reset=1 at a clock edge, clear o_data to 0, o_data_valid to 0, o_align_err to 0, fill to 0, seq to 0 and phase to 0.
REQ-028 SHALL drive o_ready=1 while i_reset=1 and on the first cycle after reset.
REQ-029 SHALL give a mid-stream reset the same result as a power-on reset; residual bits are discarded.

Structure
REQ-030 SHALL take DATA_WIDTH=32, HDR_WIDTH=2, GB_PERIOD=33, SYNC_DATA=2'b01 and SYNC_CTRL=2'b10 from shared package pcs_pkg, which the scrambler and descrambler also import.
REQ-031 SHALL be a single flat module with no sub-module; the buffer is at most 66 bits and the counter is 6 bits.

Verification
REQ-032 SHALL cover: after reset, a header beat with hdr=01, data=0xFFFFFFFF -> next cycle o_data=0xFFFFFFFD, o_data_valid=1.
REQ-033 SHALL cover: the beat after that, data=0x00000000 -> o_data=0x00000003, and a residual of 2 zero bits remains.
REQ-034 SHALL cover: a continuous valid stream for 99 cycles -> o_ready low on cycles 33, 66 and 99 only, with 96 beats accepted and 99 output words, bit-exact against a 66-bit reference model.
REQ-035 SHALL cover: a valid gap of 3 cycles at seq=10 -> seq holds at 10, the pause is delayed by 3 cycles, and no bit is lost.
REQ-036 SHALL cover: i_hdr_valid=1 on a phase-1 beat -> o_align_err pulses for 1 cycle, fill=0, and the next header beat is re-aligned.
REQ-037 SHALL cover: i_reset asserted for 1 cycle at seq=20 -> outputs are zero next cycle, o_ready=1, and seq restarts at 0.
